// File: rtl/kyber_ntt_pkg.sv
// Shared types and helpers for the Kyber NTT layer sequencer.
// Holds ring constants, the FSM encoding and butterfly address generation.
package kyber_ntt_pkg;

  localparam int N      = 256;
  localparam int LAYERS = 7;
  localparam int Q      = 3329;
  localparam int AW     = 8;
  localparam int TW     = 7;
  localparam int IW     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wb_ent_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [TW-1:0] tw;
  } bf_addr_t;

  // j = ((i & ~(len-1)) << 1) | (i & (len-1)), with len a power of two
  function automatic bf_addr_t bf_addr(
    input logic          fwd,
    input logic [2:0]    l,
    input logic [IW-1:0] i
  );
    bf_addr_t      r;
    logic [2:0]    lg;
    logic [AW-1:0] len;
    logic [IW-1:0] msk;
    logic [IW-1:0] g;
    lg    = fwd ? (3'd7 - l) : (l + 3'd1);
    len   = 8'd1 << lg;
    msk   = IW'(len - 8'd1);
    g     = i >> lg;
    r.a   = {i & ~msk, 1'b0} | {1'b0, i & msk};
    r.b   = r.a + len;
    r.tw  = fwd ? ((7'd1 << l) + g)
                : ((7'd127 >> l) - g);
    return r;
  endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Write-back delay line: carries {valid, addr_a, addr_b} for DEPTH cycles.
// Clearing on reset guarantees no stale write escapes after release.
module ntt_wb_delay
  import kyber_ntt_pkg::*;
#(
  parameter int DEPTH = 5
)(
  input  logic    clk,
  input  logic    rst_n,
  input  wb_ent_t i_ent,
  output wb_ent_t o_ent
);

  wb_ent_t r_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_sr[k] <= '0;
      end
    end else begin
      r_sr[0] <= i_ent;
      for (int k = 1; k < DEPTH; k++) begin
        r_sr[k] <= r_sr[k-1];
      end
    end
  end

  assign o_ent = r_sr[DEPTH-1];

endmodule

// File: rtl/ntt_layer_sequencer.sv
// In-place 7-layer NTT/INTT issue sequencer in front of the butterfly.
// Layers are separated by a full write-back drain.
module ntt_layer_sequencer
  import kyber_ntt_pkg::*;
#(
  parameter int BF_LAT = 4,
  parameter int RD_LAT = 1
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [TW-1:0] tw_addr,
  output logic          bf_ct,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b
);

  localparam int WB_DLY = RD_LAT + BF_LAT;
  localparam int CW     = (WB_DLY > 1) ? $clog2(WB_DLY) : 1;

  localparam logic [CW-1:0] DLAST = CW'(WB_DLY - 1);
  localparam logic [2:0]    LLAST = 3'(LAYERS - 1);
  localparam logic [IW-1:0] ILAST = '1;

  seq_state_t    r_state;
  logic [2:0]    r_layer;
  logic [IW-1:0] r_i;
  logic [CW-1:0] r_dcnt;
  logic          r_mode;

  logic     w_issue;
  logic     w_run;
  bf_addr_t w_bf;
  wb_ent_t  w_wb_in;
  wb_ent_t  w_wb_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_layer <= '0;
      r_i     <= '0;
      r_dcnt  <= '0;
      r_mode  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= ISSUE;
            r_layer <= '0;
            r_i     <= '0;
            r_mode  <= mode;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_i <= r_i + 1'b1;
          if (r_i == ILAST) begin
            r_state <= DRAIN;
            r_dcnt  <= '0;
          end
        end
        DRAIN: begin
          r_dcnt <= r_dcnt + 1'b1;
          if (r_dcnt == DLAST) begin
            if (r_layer == LLAST) begin
              r_state <= DONE;
            end else begin
              r_state <= ISSUE;
              r_layer <= r_layer + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_issue = (r_state == ISSUE);
  assign w_run   = w_issue || (r_state == DRAIN);
  assign w_bf    = bf_addr(r_mode, r_layer, r_i);

  assign busy      = w_run;
  assign done      = (r_state == DONE);
  assign rd_en     = w_issue;
  assign rd_addr_a = w_issue ? w_bf.a  : '0;
  assign rd_addr_b = w_issue ? w_bf.b  : '0;
  assign tw_addr   = w_issue ? w_bf.tw : '0;
  assign bf_ct     = w_run & r_mode;

  // Addresses ride alongside the operands so E/O land in place
  assign w_wb_in = {w_issue, rd_addr_a, rd_addr_b};

  ntt_wb_delay #(
    .DEPTH (WB_DLY)
  ) u_wb_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ent (w_wb_in),
    .o_ent (w_wb_out)
  );

  assign wr_en     = w_wb_out.v;
  assign wr_addr_a = w_wb_out.a;
  assign wr_addr_b = w_wb_out.b;

endmodule

// File: tb/tb_ntt_layer_sequencer.sv
// Bench for ntt_layer_sequencer: cycle model, literal vectors and
// an end-to-end butterfly/RAM/ROM environment against a direct NTT.
`timescale 1ns/1ps
module tb_ntt_layer_sequencer;

  localparam int BF_LAT = 4;
  localparam int RD_LAT = 1;
  localparam int W      = RD_LAT + BF_LAT;
  localparam int P      = 128 + W;
  localparam int QM     = 3329;
  localparam int HALF   = 1665;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode  = 1'b0;
  logic       busy, done, rd_en, bf_ct, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b;
  logic [7:0] wr_addr_a, wr_addr_b;
  logic [6:0] tw_addr;

  ntt_layer_sequencer #(
    .BF_LAT (BF_LAT),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .bf_ct     (bf_ct),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [6:0] tw;
    logic       bf_ct;
    logic       wr_en;
    logic [7:0] wa;
    logic [7:0] wb;
  } obs_t;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc    = 0;
  int s      = 0;
  bit act    = 1'b0;
  bit m_mode = 1'b0;

  int mem  [256];
  int x    [256];
  int gold [256];
  int pw   [256];
  int zeta [128];
  int qe [$];
  int qo [$];

  // {mode, cycle, kind(0 rd,1 wr,2 done), a, b, tw}
  int lit [10][6];

  function automatic int brv7(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 7; b++)
      if ((k & (1 << b)) != 0) r |= 1 << (6 - b);
    return r;
  endfunction

  function automatic void bf(
    input bit m, input int l, input int i,
    output int a, output int b, output int t
  );
    int len, g, o;
    len = m ? (128 >> l) : (2 << l);
    g   = i / len;
    o   = i % len;
    a   = 2 * len * g + o;
    b   = a + len;
    t   = m ? ((1 << l) + g) : ((128 >> l) - 1 - g);
  endfunction

  // Expected outputs d cycles after the accepting start edge
  function automatic obs_t model(input int d, input bit m);
    obs_t e;
    int a, b, t, l, r;
    e = '0;
    if (d >= 1 && d <= 7 * P) begin
      l = (d - 1) / P;
      r = (d - 1) % P;
      e.busy  = 1'b1;
      e.bf_ct = m;
      if (r < 128) begin
        bf(m, l, r, a, b, t);
        e.rd_en = 1'b1;
        e.ra = 8'(a);
        e.rb = 8'(b);
        e.tw = 7'(t);
      end
      if (r >= W) begin
        bf(m, l, r - W, a, b, t);
        e.wr_en = 1'b1;
        e.wa = 8'(a);
        e.wb = 8'(b);
      end
    end
    if (d == 7 * P + 1) e.done = 1'b1;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t g;
    g = {busy, done, rd_en, rd_addr_a, rd_addr_b,
         tw_addr, bf_ct, wr_en, wr_addr_a, wr_addr_b};
    return g;
  endfunction

  task automatic chk(input string nm, input bit ok,
                     input int got, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic model_trk();
    obs_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        act = 1'b0;
      end else begin
        if (act) e = model(cyc - s, m_mode);
        else e = '0;
        if (start && !e.busy) begin
          act    = 1'b1;
          s      = cyc;
          m_mode = mode;
        end
        cyc++;
      end
    end
  endtask

  task automatic monitor();
    obs_t g, e;
    int d, a, b, z, t, ev, ov, kd, ga, gb, gt;
    bit ok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qe.delete();
        qo.delete();
      end else begin
        g = sample();
        d = cyc - s;
        if (act) e = model(d, m_mode);
        else e = '0;
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL cycle_cmp d=%0d got=%h exp=%h", d, g, e);
        end
        for (int k = 0; k < 10; k++) begin
          if (act && lit[k][0] == int'(m_mode) && lit[k][1] == d) begin
            kd = lit[k][2];
            ga = 0; gb = 0; gt = 0;
            if (kd == 0) begin
              ga = rd_addr_a; gb = rd_addr_b; gt = tw_addr;
              ok = rd_en && ga == lit[k][3] && gb == lit[k][4]
                   && gt == lit[k][5] && int'(bf_ct) == lit[k][0];
            end else if (kd == 1) begin
              ga = wr_addr_a; gb = wr_addr_b;
              ok = wr_en && ga == lit[k][3] && gb == lit[k][4];
            end else begin
              ok = done && !busy;
            end
            n_tests++;
            if (!ok) begin
              n_fail++;
              $display("FAIL lit m=%0d d=%0d kind=%0d got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d",
                       lit[k][0], d, kd, ga, gb, gt,
                       lit[k][3], lit[k][4], lit[k][5]);
            end
          end
        end
        if (wr_en) begin
          if (qe.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_underflow d=%0d got=1 exp=0", d);
          end else begin
            mem[wr_addr_a] = qe.pop_front();
            mem[wr_addr_b] = qo.pop_front();
          end
        end
        if (rd_en) begin
          a = mem[rd_addr_a];
          b = mem[rd_addr_b];
          z = zeta[tw_addr];
          if (bf_ct) begin
            t  = (z * b) % QM;
            ev = (a + t) % QM;
            ov = (a - t + QM) % QM;
          end else begin
            ev = ((a + b) * HALF) % QM;
            ov = ((((b - a + QM) % QM) * z) % QM) * HALF % QM;
          end
          qe.push_back(ev);
          qo.push_back(ov);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < budget);
    chk(nm, done, k, budget);
  endtask

  // Direct definition: hat[2i+e] = sum_j x[2j+e] * zeta^((2brv7(i)+1)j)
  task automatic golden_ntt();
    int e0, p;
    longint s0, s1;
    for (int i = 0; i < 128; i++) begin
      e0 = 2 * brv7(i) + 1;
      s0 = 0;
      s1 = 0;
      for (int j = 0; j < 128; j++) begin
        p  = pw[(e0 * j) % 256];
        s0 = (s0 + longint'(x[2*j]) * p) % QM;
        s1 = (s1 + longint'(x[2*j+1]) * p) % QM;
      end
      gold[2*i]   = int'(s0);
      gold[2*i+1] = int'(s1);
    end
  endtask

  task automatic check_mem(input string nm);
    int bad, first;
    bad = 0;
    first = -1;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] != gold[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s bad=%0d idx=%0d got=%0d exp=%0d",
               nm, bad, first, mem[first], gold[first]);
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 256; i++) begin
      x[i]   = int'($urandom_range(0, QM - 1));
      mem[i] = x[i];
    end
  endtask

  initial begin
    int cnt;
    pw[0] = 1;
    for (int k = 1; k < 256; k++) pw[k] = (pw[k-1] * 17) % QM;
    for (int k = 0; k < 128; k++) zeta[k] = pw[brv7(k)];
    lit = '{'{1,   1, 0, 0, 128,   1},
            '{1,   2, 0, 1, 129,   1},
            '{1,   6, 1, 0, 128,   0},
            '{1, 134, 0, 0,  64,   2},
            '{1, 801, 0, 4,   6,  65},
            '{1, 932, 2, 0,   0,   0},
            '{0,   1, 0, 0,   2, 127},
            '{0,   3, 0, 4,   6, 126},
            '{0, 799, 0, 0, 128,   1},
            '{0, 932, 2, 0,   0,   0}};

    fork
      model_trk();
      monitor();
      begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", sample() == '0, $countones(sample()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (rd_en || wr_en || busy) cnt++;
    end
    chk("idle_quiet", cnt == 0, cnt, 0);
    tick();

    // forward run; ignored pulse mid-run; start held into DONE
    load_random();
    golden_ntt();
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (498) tick();
    start = 1'b1;
    mode  = 1'b0;
    tick();
    start = 1'b0;
    repeat (400) tick();
    start = 1'b1;
    wait_done(200, "done_fwd");
    check_mem("fwd_ntt");
    for (int i = 0; i < 256; i++) gold[i] = x[i];
    tick();
    start = 1'b0;
    wait_done(1000, "done_inv");
    check_mem("inv_roundtrip");

    // reset in the middle of a run
    tick();
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (299) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid", sample() == '0, $countones(sample()), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (wr_en || rd_en || busy) cnt++;
    end
    chk("no_stale_wr", cnt == 0, cnt, 0);

    // second forward polynomial after reset
    tick();
    load_random();
    golden_ntt();
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1000, "done_fwd2");
    check_mem("fwd_ntt2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
